// File: rtl/jzjpcc_fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: the NOP filler and the {instr, pc} entry layout.
package jzjpcc_pkg;
    localparam int          PC_MAX_B  = 31;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0]       instr;
        logic [PC_MAX_B:2] pc;
    } fetch_entry_t;
endpackage

// File: rtl/jzjpcc_fetch_queue_if.sv
// Fetch-to-decode bus around the queue; master is the fetch/decode environment, slave is the queue.
interface jzjpcc_fetch_queue_if;
    import jzjpcc_pkg::*;

    logic                  fetch_valid;
    logic [31:0]           instruction_fetch;
    logic [PC_MAX_B:2]     pc_fetch;
    logic                  flush;
    logic                  stall_decode;
    logic                  stall_fetch;
    logic                  valid_decode;
    logic [31:0]           instruction_decode;
    logic [PC_MAX_B:2]     pc_decode;
    logic                  overflow;

    modport master (
        output fetch_valid, instruction_fetch, pc_fetch, flush, stall_decode,
        input  stall_fetch, valid_decode, instruction_decode, pc_decode, overflow
    );

    modport slave (
        input  fetch_valid, instruction_fetch, pc_fetch, flush, stall_decode,
        output stall_fetch, valid_decode, instruction_decode, pc_decode, overflow
    );
endinterface

// File: rtl/jzjpcc_fetch_queue_fifo_ctrl.sv
// Pointer/count bookkeeping for the fetch queue; qualifies push and pop and flags pushes into a full queue.
module jzjpcc_fetch_queue_fifo_ctrl
    import jzjpcc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       fetch_valid_i,
    input  logic                       flush_i,
    input  logic                       stall_decode_i,
    output logic                       push_o,
    output logic                       pop_o,
    output logic                       ovf_push_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     count_d_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full, empty, push, pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign pop   = !empty && !stall_decode_i && !flush_i;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push  = fetch_valid_i && !flush_i && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign push_o     = push;
    assign pop_o      = pop;
    assign ovf_push_o = fetch_valid_i && !flush_i && full && !pop;
    assign rd_ptr_o   = rd_ptr_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign count_o    = count_q;
    assign count_d_o  = count_d;
endmodule

// File: rtl/jzjpcc_fetch_queue.sv
// Instruction queue between fetch and decode: in-order storage, registered fetch backpressure,
// flush of wrong-path entries and a sticky overflow flag.
module jzjpcc_fetch_queue
    import jzjpcc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    jzjpcc_fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

    logic          push, pop, ovf_push;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_d;

    jzjpcc_fetch_queue_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_valid_i  (bus.fetch_valid),
        .flush_i        (bus.flush),
        .stall_decode_i (bus.stall_decode),
        .push_o         (push),
        .pop_o          (pop),
        .ovf_push_o     (ovf_push),
        .rd_ptr_o       (rd_ptr),
        .wr_ptr_o       (wr_ptr),
        .count_o        (count),
        .count_d_o      (count_d)
    );

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t head;
    logic         stall_fetch_q, stall_fetch_d;
    logic         overflow_q,    overflow_d;

    // Storage is deliberately left uninitialised; valid_decode gates it.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr] <= '{instr: bus.instruction_fetch, pc: bus.pc_fetch};
    end

    // Stall one entry early so the fetch already in flight lands in the spare slot.
    assign stall_fetch_d = (count_d >= STALL_AT);
    assign overflow_d    = overflow_q || ovf_push;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_fetch_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            stall_fetch_q <= stall_fetch_d;
            overflow_q    <= overflow_d;
        end
    end

    assign head                   = mem_q[rd_ptr];
    assign bus.valid_decode       = (count != '0);
    assign bus.instruction_decode = bus.valid_decode ? head.instr : NOP_INSTR;
    assign bus.pc_decode          = bus.valid_decode ? head.pc : '0;
    assign bus.stall_fetch        = stall_fetch_q;
    assign bus.overflow           = overflow_q;

    logic unused_pop;
    assign unused_pop = pop;
endmodule
